// File: rtl/upscale_pkg.sv
// Shared types and per-channel rounding averages for the 2x bilinear upscaler.
package upscale_pkg;

    // Row-level phases: fill the next line buffer, then emit the even and odd output rows.
    typedef enum logic [1:0] {
        LOAD = 2'd0,
        EVEN = 2'd1,
        ODD  = 2'd2
    } upscale_state_e;

    // Widest channel the averaging helpers support. A channel of bit_depth bits is
    // zero-extended into chan_t. The rounded average of such values fits back into
    // bit_depth bits, so the caller keeps only the low bit_depth bits of the result.
    localparam int MAX_BIT_DEPTH = 16;

    typedef logic [MAX_BIT_DEPTH-1:0] chan_t;
    typedef logic [MAX_BIT_DEPTH+1:0] wide_t;

    localparam wide_t WIDE_ONE = wide_t'(1);
    localparam wide_t WIDE_TWO = wide_t'(2);

    // Rounded mean of two channel values: (a + b + 1) >> 1, computed 2 bits wider.
    function automatic chan_t avg2(input chan_t a, input chan_t b);
        wide_t sum;
        sum = {2'b00, a} + {2'b00, b} + WIDE_ONE;
        return chan_t'(sum >> 1);
    endfunction

    // Rounded mean of four channel values: (a + b + d + e + 2) >> 2, computed 2 bits wider.
    function automatic chan_t avg4(input chan_t a, input chan_t b, input chan_t d, input chan_t e);
        wide_t sum;
        sum = {2'b00, a} + {2'b00, b} + {2'b00, d} + {2'b00, e} + WIDE_TWO;
        return chan_t'(sum >> 2);
    endfunction

endpackage

// File: rtl/line_buffer.sv
// One row of pixels: a single write port and two combinational read ports.
module line_buffer #(
    parameter  int depth = 4,
    parameter  int width = 24,
    localparam int aw    = $clog2(depth)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             we,
    input  logic [aw-1:0]    waddr,
    input  logic [width-1:0] wdata,
    input  logic [aw-1:0]    raddr_a,
    input  logic [aw-1:0]    raddr_b,
    output logic [width-1:0] rdata_a,
    output logic [width-1:0] rdata_b
);

    logic [width-1:0] mem [depth];

    // Clear the row on reset, otherwise store the written pixel.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < depth; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata_a = mem[raddr_a];
    assign rdata_b = mem[raddr_b];

endmodule

// File: rtl/bilinear_upscale_2x.sv
// Streaming 2x bilinear upscaler with edge replication and frame markers.
//
// Handshake: a transfer happens on a rising edge where valid and ready are both high.
// A producer holds its data stable while valid is high and ready is low, and valid
// never waits on ready. This applies to valid_in/ready_out and valid_out/ready_in.
module bilinear_upscale_2x
    import upscale_pkg::*;
#(
    parameter int bit_depth = 8,
    parameter int channels  = 3,
    parameter int h_res     = 4,
    parameter int v_res     = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          valid_in,
    output logic                          ready_out,
    input  logic [channels*bit_depth-1:0] data_in,
    output logic                          valid_out,
    input  logic                          ready_in,
    output logic [channels*bit_depth-1:0] data_out,
    output logic                          sof_out,
    output logic                          eol_out,
    output upscale_state_e                state_dbg
);

    localparam int W   = channels * bit_depth;
    localparam int ICW = $clog2(h_res);
    localparam int OCW = ICW + 1;
    localparam int RW  = $clog2(v_res);

    localparam logic [ICW-1:0] IN_LAST  = ICW'(h_res - 1);
    localparam logic [ICW-1:0] IC_ONE   = ICW'(1);
    localparam logic [OCW-1:0] OUT_LAST = OCW'(2 * h_res - 1);
    localparam logic [OCW-1:0] OC_ONE   = OCW'(1);
    localparam logic [RW-1:0]  ROW_LAST = RW'(v_res - 1);
    localparam logic [RW-1:0]  ROW_ONE  = RW'(1);

    upscale_state_e state, state_next;

    logic [ICW-1:0] in_col;     // next column written while loading
    logic [OCW-1:0] out_col;    // output column C of the row being emitted
    logic [RW-1:0]  row;        // input row r held in the cur buffer
    logic           sel;        // 0: buf0 is cur, buf1 is nxt; 1: swapped
    logic           first;      // the next LOAD fetches row 0 of a new frame
    logic           prime;      // one turnaround cycle after a row load

    logic           in_fire, emit, row_done_in, row_done_out, rep;
    logic [ICW-1:0] src_c, src_c1;
    logic [W-1:0]   b0_a, b0_b, b1_a, b1_b;
    logic [W-1:0]   cur_a, cur_b, nxt_a, nxt_b, d_pix, e_pix, pix;
    chan_t          ca, cb, cd, ce, res;

    assign ready_out    = (state == LOAD);
    assign state_dbg    = state;
    assign in_fire      = ready_out && valid_in;
    assign row_done_in  = in_fire && (in_col == IN_LAST);
    assign emit         = (state != LOAD) && !prime && (!valid_out || ready_in);
    assign row_done_out = emit && (out_col == OUT_LAST);

    // Source columns c and c+1, with c+1 clamped to the last column.
    assign src_c  = out_col[OCW-1:1];
    assign src_c1 = (src_c == IN_LAST) ? src_c : src_c + IC_ONE;

    line_buffer #(.depth(h_res), .width(W)) u_buf0 (
        .clk     (clk),
        .reset   (reset),
        .we      (in_fire && sel),
        .waddr   (in_col),
        .wdata   (data_in),
        .raddr_a (src_c),
        .raddr_b (src_c1),
        .rdata_a (b0_a),
        .rdata_b (b0_b)
    );

    line_buffer #(.depth(h_res), .width(W)) u_buf1 (
        .clk     (clk),
        .reset   (reset),
        .we      (in_fire && !sel),
        .waddr   (in_col),
        .wdata   (data_in),
        .raddr_a (src_c),
        .raddr_b (src_c1),
        .rdata_a (b1_a),
        .rdata_b (b1_b)
    );

    assign cur_a = sel ? b1_a : b0_a;
    assign cur_b = sel ? b1_b : b0_b;
    assign nxt_a = sel ? b0_a : b1_a;
    assign nxt_b = sel ? b0_b : b1_b;

    // The odd row after the last input row replicates the bottom edge.
    assign rep   = (row == ROW_LAST);
    assign d_pix = rep ? cur_a : nxt_a;
    assign e_pix = rep ? cur_b : nxt_b;

    // Per-channel interpolation selected by output row parity (state) and column parity.
    always_comb begin
        pix = '0;
        ca  = '0;
        cb  = '0;
        cd  = '0;
        ce  = '0;
        res = '0;
        for (int ch = 0; ch < channels; ch++) begin
            ca = '0;
            cb = '0;
            cd = '0;
            ce = '0;
            ca[bit_depth-1:0] = cur_a[ch*bit_depth +: bit_depth];
            cb[bit_depth-1:0] = cur_b[ch*bit_depth +: bit_depth];
            cd[bit_depth-1:0] = d_pix[ch*bit_depth +: bit_depth];
            ce[bit_depth-1:0] = e_pix[ch*bit_depth +: bit_depth];
            case ({state == ODD, out_col[0]})
                2'b00:   res = ca;
                2'b01:   res = avg2(ca, cb);
                2'b10:   res = avg2(ca, cd);
                default: res = avg4(ca, cb, cd, ce);
            endcase
            pix[ch*bit_depth +: bit_depth] = res[bit_depth-1:0];
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= LOAD;
        end else begin
            state <= state_next;
        end
    end

    // Next state: advance when a full input row is loaded or a full output row is emitted.
    always_comb begin
        state_next = state;
        case (state)
            LOAD:    if (row_done_in)  state_next = first ? EVEN : ODD;
            EVEN:    if (row_done_out) state_next = (row == ROW_LAST) ? ODD : LOAD;
            ODD:     if (row_done_out) state_next = (row == ROW_LAST) ? LOAD : EVEN;
            default: state_next = LOAD;
        endcase
    end

    // Column/row counters and ping-pong buffer selection.
    always_ff @(posedge clk) begin
        if (reset) begin
            in_col  <= '0;
            out_col <= '0;
            row     <= '0;
            sel     <= 1'b0;
            first   <= 1'b1;
            prime   <= 1'b0;
        end else begin
            prime <= row_done_in;
            if (in_fire) begin
                in_col <= (in_col == IN_LAST) ? '0 : in_col + IC_ONE;
            end
            if (emit) begin
                out_col <= (out_col == OUT_LAST) ? '0 : out_col + OC_ONE;
            end
            // Row 0 lands in nxt; swap so it becomes cur for the first even row.
            if (row_done_in && first) begin
                sel   <= ~sel;
                first <= 1'b0;
                row   <= '0;
            end
            // After an odd row, row r+1 (in nxt) becomes cur, or the frame ends.
            if (row_done_out && (state == ODD)) begin
                if (row == ROW_LAST) begin
                    first <= 1'b1;
                end else begin
                    sel <= ~sel;
                    row <= row + ROW_ONE;
                end
            end
        end
    end

    // Output register: load a new pixel when empty or consumed, otherwise hold.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_out <= 1'b0;
            data_out  <= '0;
            sof_out   <= 1'b0;
            eol_out   <= 1'b0;
        end else if (emit) begin
            valid_out <= 1'b1;
            data_out  <= pix;
            sof_out   <= (state == EVEN) && (row == '0) && (out_col == '0);
            eol_out   <= (out_col == OUT_LAST);
        end else if (ready_in) begin
            valid_out <= 1'b0;
        end
    end

endmodule

// File: tb/tb_bilinear_upscale_2x.sv
// Bench for bilinear_upscale_2x: a 1-channel 2x2 instance driven from a vector table
// and a 3-channel 4x4 instance checked against a reference model.
module tb_bilinear_upscale_2x;
    import upscale_pkg::*;

    logic clk, reset, ready_in, rand_rdy;

    logic           vs_in, rs_out, vs_out, sof_s, eol_s;
    logic [7:0]     ds_in, ds_out;
    upscale_state_e st_s;

    logic           vm_in, rm_out, vm_out, sof_m, eol_m;
    logic [23:0]    dm_in, dm_out;
    upscale_state_e st_m;

    int n_vec, n_fail, sof_cnt_m, frames_m;

    logic [9:0]  exp_s_q[$];
    logic [25:0] exp_m_q[$];

    typedef struct {
        logic [7:0] px [4];
        logic [7:0] ex [16];
    } vec_t;
    vec_t vecs [3];

    logic [23:0] fr_m [4][4];

    bilinear_upscale_2x #(.bit_depth(8), .channels(1), .h_res(2), .v_res(2)) dut_s (
        .clk       (clk),
        .reset     (reset),
        .valid_in  (vs_in),
        .ready_out (rs_out),
        .data_in   (ds_in),
        .valid_out (vs_out),
        .ready_in  (ready_in),
        .data_out  (ds_out),
        .sof_out   (sof_s),
        .eol_out   (eol_s),
        .state_dbg (st_s)
    );

    bilinear_upscale_2x #(.bit_depth(8), .channels(3), .h_res(4), .v_res(4)) dut_m (
        .clk       (clk),
        .reset     (reset),
        .valid_in  (vm_in),
        .ready_out (rm_out),
        .data_in   (dm_in),
        .valid_out (vm_out),
        .ready_in  (ready_in),
        .data_out  (dm_out),
        .sof_out   (sof_m),
        .eol_out   (eol_m),
        .state_dbg (st_m)
    );

    // Clock and reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Downstream ready: constant or pseudo-random, changed just after each rising edge.
    initial begin
        ready_in = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            ready_in = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    // Driver: present one pixel and hold it until accepted, with optional idle gaps first.
    task automatic send(input bit to_m, input logic [23:0] p, input bit gaps);
        int n;
        if (gaps) begin
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
        end
        if (to_m) begin
            dm_in = p;
            vm_in = 1'b1;
        end else begin
            ds_in = p[7:0];
            vs_in = 1'b1;
        end
        n = 0;
        @(negedge clk);
        while (!(to_m ? rm_out : rs_out) && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (n >= 500) check("send_timeout", 32'(to_m ? rm_out : rs_out), 32'd1);
        @(posedge clk);
        #1;
        vm_in = 1'b0;
        vs_in = 1'b0;
    endtask

    task automatic push_exp_s(input int i);
        for (int k = 0; k < 16; k++) begin
            exp_s_q.push_back({(k == 0), (k % 4 == 3), vecs[i].ex[k]});
        end
    endtask

    task automatic send_frame_s(input int i, input bit gaps);
        push_exp_s(i);
        for (int p = 0; p < 4; p++) send(1'b0, {16'd0, vecs[i].px[p]}, gaps);
    endtask

    // Reference model for the 4x4, 3-channel instance, straight from the interpolation formulas.
    function automatic logic [23:0] ref_m(input int rr, input int cc);
        int r, c, r1, c1, a, b, d, e, v;
        logic [23:0] res;
        r   = rr / 2;
        c   = cc / 2;
        r1  = (r < 3) ? r + 1 : 3;
        c1  = (c < 3) ? c + 1 : 3;
        res = '0;
        for (int ch = 0; ch < 3; ch++) begin
            a = int'(fr_m[r][c][ch*8 +: 8]);
            b = int'(fr_m[r][c1][ch*8 +: 8]);
            d = int'(fr_m[r1][c][ch*8 +: 8]);
            e = int'(fr_m[r1][c1][ch*8 +: 8]);
            if (rr % 2 == 0 && cc % 2 == 0)  v = a;
            else if (rr % 2 == 0)            v = (a + b + 1) / 2;
            else if (cc % 2 == 0)            v = (a + d + 1) / 2;
            else                             v = (a + b + d + e + 2) / 4;
            res[ch*8 +: 8] = v[7:0];
        end
        return res;
    endfunction

    task automatic send_frame_m(input bit fixed01, input bit gaps);
        logic [23:0] e;
        for (int rr = 0; rr < 8; rr++) begin
            for (int cc = 0; cc < 8; cc++) begin
                e = ref_m(rr, cc);
                if (fixed01 && rr == 0 && cc == 1) e = {8'd255, 8'd1, 8'd1};
                exp_m_q.push_back({(rr == 0 && cc == 0), (cc == 7), e});
            end
        end
        frames_m++;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) send(1'b1, fr_m[r][c], gaps);
        end
    endtask

    // Wait (bounded) for every expected pixel to come out.
    task automatic drain();
        int n;
        n = 0;
        while ((exp_s_q.size() != 0 || exp_m_q.size() != 0) && n < 3000) begin
            @(posedge clk);
            n++;
        end
        check("drain_pending", 32'(exp_s_q.size() + exp_m_q.size()), 32'd0);
        exp_s_q.delete();
        exp_m_q.delete();
        repeat (2) @(posedge clk);
        #1;
    endtask

    // Scoreboard, small instance: compare the head on every valid cycle, pop on handshake.
    always @(negedge clk) begin
        if (!reset) begin
            if (st_s != LOAD) check("ready_s_busy", 32'(rs_out), 32'd0);
            if (vs_out) begin
                if (exp_s_q.size() == 0) begin
                    check("extra_out_s", 32'(vs_out), 32'd0);
                end else begin
                    check("out_s", 32'({sof_s, eol_s, ds_out}), 32'(exp_s_q[0]));
                    if (ready_in) void'(exp_s_q.pop_front());
                end
            end
        end
    end

    // Scoreboard, 3-channel instance.
    always @(negedge clk) begin
        if (!reset) begin
            if (st_m != LOAD) check("ready_m_busy", 32'(rm_out), 32'd0);
            if (vm_out) begin
                if (exp_m_q.size() == 0) begin
                    check("extra_out_m", 32'(vm_out), 32'd0);
                end else begin
                    check("out_m", 32'({sof_m, eol_m, dm_out}), 32'(exp_m_q[0]));
                    if (ready_in) begin
                        if (sof_m) sof_cnt_m++;
                        void'(exp_m_q.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        int n;
        n_vec = 0;  n_fail = 0;  sof_cnt_m = 0;  frames_m = 0;
        rand_rdy = 1'b0;
        reset = 1'b1;
        vs_in = 1'b0;  ds_in = '0;
        vm_in = 1'b0;  dm_in = '0;

        vecs[0].px = '{8'd10, 8'd20, 8'd30, 8'd40};
        vecs[0].ex = '{8'd10, 8'd15, 8'd20, 8'd20, 8'd20, 8'd25, 8'd30, 8'd30,
                       8'd30, 8'd35, 8'd40, 8'd40, 8'd30, 8'd35, 8'd40, 8'd40};
        vecs[1].px = '{8'd1, 8'd2, 8'd4, 8'd7};
        vecs[1].ex = '{8'd1, 8'd2, 8'd2, 8'd2, 8'd3, 8'd4, 8'd5, 8'd5,
                       8'd4, 8'd6, 8'd7, 8'd7, 8'd4, 8'd6, 8'd7, 8'd7};
        vecs[2].px = '{8'd255, 8'd0, 8'd0, 8'd255};
        vecs[2].ex = '{8'd255, 8'd128, 8'd0, 8'd0, 8'd128, 8'd128, 8'd128, 8'd128,
                       8'd0, 8'd128, 8'd255, 8'd255, 8'd0, 8'd128, 8'd255, 8'd255};

        // Reset state of both instances
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_valid_s", 32'(vs_out), 32'd0);
        check("rst_data_s",  32'(ds_out), 32'd0);
        check("rst_sof_s",   32'(sof_s),  32'd0);
        check("rst_eol_s",   32'(eol_s),  32'd0);
        check("rst_ready_s", 32'(rs_out), 32'd1);
        check("rst_valid_m", 32'(vm_out), 32'd0);
        check("rst_data_m",  32'(dm_out), 32'd0);
        check("rst_ready_m", 32'(rm_out), 32'd1);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // First frame by hand: valid_out rises two edges after the row's last pixel is taken
        push_exp_s(0);
        send(1'b0, {16'd0, vecs[0].px[0]}, 1'b0);
        send(1'b0, {16'd0, vecs[0].px[1]}, 1'b0);
        @(negedge clk);
        @(negedge clk);
        check("latency_edge1", 32'(vs_out), 32'd0);
        @(negedge clk);
        check("latency_edge2", 32'(vs_out), 32'd1);
        @(posedge clk);
        #1;
        send(1'b0, {16'd0, vecs[0].px[2]}, 1'b0);
        send(1'b0, {16'd0, vecs[0].px[3]}, 1'b0);
        drain();

        // Table: every frame with free-running output, then with gaps and backpressure
        for (int i = 0; i < 3; i++) begin
            send_frame_s(i, i == 1);
            drain();
        end
        rand_rdy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            send_frame_s(i, 1'b1);
            drain();
        end
        rand_rdy = 1'b0;

        // Reset while an odd row is being emitted, then a clean frame
        send_frame_s(1, 1'b0);
        n = 0;
        @(negedge clk);
        while (!(st_s == ODD && vs_out) && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("reach_odd", 32'(st_s), 32'(ODD));
        reset = 1'b1;
        @(negedge clk);
        check("abort_valid", 32'(vs_out), 32'd0);
        check("abort_ready", 32'(rs_out), 32'd1);
        check("abort_data",  32'(ds_out), 32'd0);
        exp_s_q.delete();
        reset = 1'b0;
        @(posedge clk);
        #1;
        send_frame_s(0, 1'b0);
        drain();

        // 3 channels: rounding without inter-channel carry, gaps and backpressure
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) fr_m[r][c] = 24'($urandom);
        end
        fr_m[0][0] = {8'd255, 8'd0, 8'd1};
        fr_m[0][1] = {8'd255, 8'd1, 8'd0};
        rand_rdy = 1'b1;
        send_frame_m(1'b1, 1'b1);
        drain();
        rand_rdy = 1'b0;

        // Two back-to-back ramp frames
        for (int f = 0; f < 2; f++) begin
            for (int r = 0; r < 4; r++) begin
                for (int c = 0; c < 4; c++) begin
                    n = 16 * r + 4 * c;
                    fr_m[r][c] = (f == 0) ? {8'(n), 8'(n), 8'(n)} : {8'(n + 3), 8'(255 - n), 8'(n)};
                end
            end
            send_frame_m(1'b0, 1'b0);
        end
        drain();
        check("sof_count_m", 32'(sof_cnt_m), 32'(frames_m));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/bilinear_upscale_2x.md
# bilinear_upscale_2x

Streaming 2x bilinear upscaler: accepts a raster frame of `h_res` x `v_res` multi-channel pixels over a ready/valid input and emits a `2*h_res` x `2*v_res` frame over a ready/valid output with downstream backpressure. It is the parametrised successor to the single-channel fixed-window interpolator. It adds per-channel packing, true two-sided handshaking, edge replication in place of zero padding, and frame markers. It sits between the pixel source (DMA/sensor unpack) and the display/writeback stage.

## Interface
- `bit_depth`, 8, bits per channel
- `channels`, 3, channels packed per pixel, channel 0 in LSBs
- `h_res`, 4, input pixels per row, ≥2
- `v_res`, 4, input rows per frame, ≥2
- `clk` in 1 — single clock, all logic on rising edge
- `reset` in 1 — synchronous, active-high
- `valid_in` in 1 — input pixel valid
- `ready_out` out 1 — block can accept input pixel
- `data_in` in `channels*bit_depth` — input pixel
- `valid_out` out 1 — output pixel valid
- `ready_in` in 1 — downstream accepts output pixel
- `data_out` out `channels*bit_depth` — output pixel
- `sof_out` out 1 — qualifies `data_out` as output pixel (0,0)
- `eol_out` out 1 — qualifies `data_out` as last pixel of an output row

## Operation
- Input pixel `in(r,c)`. Output pixel `out(R,C)`. `A=in(r,c)`, `B=in(r,c+1)`, `D=in(r+1,c)`, `E=in(r+1,c+1)`. Out-of-range indices clamp to the last row/column (edge replication).
- `out(2r,2c)=A`. `out(2r,2c+1)=(A+B+1)>>1`. `out(2r+1,2c)=(A+D+1)>>1`. `out(2r+1,2c+1)=(A+B+D+E+2)>>2`.
- All arithmetic is per channel and unsigned. Sums are widened by 2 bits, then truncated after the shift. No cross-channel carry.
- Two row buffers of `h_res` pixels used ping-pong: `cur` holds row r, `nxt` holds row r+1.
- FSM states:
  - `LOAD`: `ready_out=1`. Each handshake writes `nxt[col]`. After `h_res` pixels, swap/advance and go to `EVEN` (row 0) or `ODD` (otherwise).
  - `EVEN`: emits output row 2r from `cur`.
  - `ODD`: emits output row 2r+1 from `cur`/`nxt`.
- Transitions:
  - Reset enters `LOAD` with row=0.
  - `EVEN`, r < `v_res`-1 → `LOAD` (row r+1).
  - `EVEN`, r = `v_res`-1 → `ODD` with bottom replication (D=A, E=B).
  - `ODD`, not last → `EVEN` for row r+1.
  - `ODD`, last → `LOAD` for row 0 of the next frame.
- `ready_out=0` in `EVEN`/`ODD`. Input is never dropped.
- Output stage is a single register. It loads when `!valid_out || ready_in`, and holds `data_out`/`sof_out`/`eol_out` stable while `valid_out && !ready_in`.

## Timing
- Reset values: `valid_out=0`, `data_out=0`, `sof_out=0`, `eol_out=0`, `ready_out=1` (state `LOAD`). Counters and buffers are cleared.
- Reset asserted mid-frame aborts immediately. The next cycle is the reset state and the partial frame is discarded.
- `valid_out` rises 2 edges after the edge accepting the final pixel of a row.
- With `ready_in=1`: one output pixel per cycle, and no bubble on `EVEN→ODD` or `ODD→EVEN`.
- Output column counter advances only on output-register load, so stalls never skip or repeat pixels.
- One frame needs `h_res*v_res` input cycles plus `4*h_res*v_res` output cycles minimum.
- `eol_out` is high on output column `2*h_res-1`. `sof_out` is high on R=0, C=0 only.

## Structure
- Package `upscale_pkg`: state enum (`LOAD`, `EVEN`, `ODD`), functions `avg2`/`avg4` parametrised by `bit_depth`.
- Sub-module `line_buffer` (`h_res` x `channels*bit_depth`, 1 write port, 2 combinational read ports). It is instantiated twice.

## Test plan
- Defaults with `channels=1`, `h_res=2`, `v_res=2`, input 10,20 / 30,40, `ready_in=1` → rows 10,15,20,20 / 20,25,30,30 / 30,35,40,40 / 30,35,40,40. `sof_out` on first pixel, `eol_out` on every 4th.
- Same frame with `ready_in` toggling pseudo-randomly → identical sequence; `data_out` stable on every stalled cycle.
- `channels=3`, pixel {255,0,1} next to {255,1,0} → horizontal average {255,1,1}. Check rounding and no inter-channel carry.
- `valid_in` gaps inside `LOAD` → output unchanged. `ready_out` is 0 throughout `EVEN`/`ODD`.
- Reset asserted mid-`ODD` → next cycle `valid_out=0`, `ready_out=1`. A following frame is processed correctly.
- Two back-to-back 4x4 ramp frames (value = 16r+4c) → each 8x8 output matches the reference model, and `sof_out` fires once per frame.
